// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline: opcodes, fetch state encoding
// and the sequential PC increment.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b00_0000;
    localparam logic [5:0] OP_ADDI  = 6'b00_1000;
    localparam logic [5:0] OP_LW    = 6'b10_0011;
    localparam logic [5:0] OP_SW    = 6'b10_1011;
    localparam logic [5:0] OP_BEQ   = 6'b00_0100;
    localparam logic [5:0] OP_J     = 6'b00_0010;
    localparam logic [5:0] OP_HALT  = 6'b11_1111;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        ISSUE  = 2'b01,
        HALTED = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: reset load, sequential increment, and word-aligned redirect load.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc,
    input  logic        i_load,
    input  logic [31:0] i_load_pc,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // PC update; redirect wins over increment and its low two bits are dropped
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= {i_load_pc[31:2], 2'b00};
        end else if (i_inc) begin
            r_pc <= r_pc + PC_STEP;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: req/ack fetch from instruction memory into the IF/ID register.
// Optional IFETCH_PERF_CNT_EN adds a saturating fetch_count output.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = OP_HALT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        id_ready,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        halted
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    fetch_state_e r_state;
    logic         r_imem_req;
    logic [31:0]  r_instr;
    logic [31:0]  r_pc_plus4;
    logic         r_instr_valid;
    logic         r_halted;
    logic [31:0]  w_pc;
    logic         w_redirect;
    logic         w_pc_inc;
    logic         w_ack_take;

    assign w_redirect = redirect_en && (r_state != HALTED);
    assign w_pc_inc   = (r_state == ISSUE) && id_ready && !redirect_en &&
                        (r_instr[31:26] != HALT_OPCODE);
    // An ack only counts while a request is actually outstanding and no redirect overrides it
    assign w_ack_take = (r_state == FETCH) && r_imem_req && imem_ack && !redirect_en;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_inc     (w_pc_inc),
        .i_load    (w_redirect),
        .i_load_pc (redirect_pc),
        .o_pc      (w_pc)
    );

    // Fetch FSM and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_imem_req    <= 1'b0;
            r_instr       <= 32'h0000_0000;
            r_pc_plus4    <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (redirect_en) begin
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                    end else if (w_ack_take) begin
                        r_instr       <= imem_rdata;
                        r_pc_plus4    <= w_pc + PC_STEP;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= ISSUE;
                    end else begin
                        r_imem_req    <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (redirect_en) begin
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= FETCH;
                    end else if (id_ready && (r_instr[31:26] == HALT_OPCODE)) begin
                        r_instr_valid <= 1'b0;
                        r_halted      <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= HALTED;
                    end else if (id_ready) begin
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= FETCH;
                    end else begin
                        r_imem_req    <= 1'b0;
                    end
                end
                HALTED: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end
                default: begin
                    r_state       <= FETCH;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;

    // Saturating count of accepted, non-discarded fetches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'h0000_0000;
        end else if (w_ack_take && (r_fetch_count != 32'hFFFF_FFFF)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    assign imem_req    = r_imem_req;
    assign imem_addr   = w_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign pc_plus4    = r_pc_plus4;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table of fetch transactions with a
// scoreboard of expected IF/ID contents, plus redirect, halt and reset sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, wr_imem_req;
    logic [31:0] imem_addr, wr_imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr, wr_instr;
    logic [5:0]  opcode, wr_opcode;
    logic [31:0] pc_plus4, wr_pc_plus4;
    logic        instr_valid, wr_instr_valid;
    logic        id_ready;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halted, wr_halted;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count, wr_fetch_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          ack_lat;
        int          stall;
        logic [31:0] addr;
        logic        halt;
    } fetch_rec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    fetch_rec_t tbl[6];
    exp_t       sb[$];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk (clk), .rst (rst),
        .imem_req (imem_req), .imem_addr (imem_addr),
        .imem_rdata (imem_rdata), .imem_ack (imem_ack),
        .instr (instr), .opcode (opcode), .pc_plus4 (pc_plus4),
        .instr_valid (instr_valid), .id_ready (id_ready),
        .redirect_en (redirect_en), .redirect_pc (redirect_pc),
        .halted (halted)
`ifdef IFETCH_PERF_CNT_EN
        , .fetch_count (fetch_count)
`endif
    );

    // Second instance runs in lockstep on the same inputs to exercise a wrapping reset PC
    instr_fetch #(.RESET_PC (32'hFFFF_FFFC)) u_wrap (
        .clk (clk), .rst (rst),
        .imem_req (wr_imem_req), .imem_addr (wr_imem_addr),
        .imem_rdata (imem_rdata), .imem_ack (imem_ack),
        .instr (wr_instr), .opcode (wr_opcode), .pc_plus4 (wr_pc_plus4),
        .instr_valid (wr_instr_valid), .id_ready (id_ready),
        .redirect_en (redirect_en), .redirect_pc (redirect_pc),
        .halted (wr_halted)
`ifdef IFETCH_PERF_CNT_EN
        , .fetch_count (wr_fetch_count)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_000C)      return 32'h2008_0005;
        else if (a == 32'h0000_0200) return 32'hFC00_0000;
        else                         return 32'h8C00_0000 | a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_fetch(input fetch_rec_t r);
        int          w;
        logic        ok;
        logic [31:0] word;
        exp_t        e;
        id_ready = 1'b0; imem_ack = 1'b0; redirect_en = 1'b0;
        w = 0;
        while (imem_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_wait", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, r.addr);
        ok = 1'b1;
        for (int i = 0; i < r.ack_lat; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b1 || imem_addr !== r.addr) ok = 1'b0;
        end
        check("req_hold", 32'(ok), 32'd1);
        word = mem_word(imem_addr);
        imem_rdata = word;
        imem_ack   = 1'b1;
        sb.push_back('{word, r.addr + 32'd4});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("valid_latency", 32'(instr_valid), 32'd1);
        check("req_in_issue", 32'(imem_req), 32'd0);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("instr", instr, e.instr);
            check("opcode", 32'(opcode), 32'(e.instr[31:26]));
            check("pc_plus4", pc_plus4, e.pc4);
            ok = 1'b1;
            for (int i = 0; i < r.stall; i++) begin
                @(negedge clk);
                if (instr !== e.instr || opcode !== e.instr[31:26] || instr_valid !== 1'b1 ||
                    imem_req !== 1'b0 || pc_plus4 !== e.pc4) ok = 1'b0;
            end
            check("stall_hold", 32'(ok), 32'd1);
        end
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        check("valid_drop", 32'(instr_valid), 32'd0);
        if (r.halt) begin
            check("halted_set", 32'(halted), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
        end else begin
            check("next_req", 32'(imem_req), 32'd1);
            check("next_addr", imem_addr, r.addr + 32'd4);
        end
    endtask

    initial begin
        logic ok;
        tbl[0] = '{1, 0, 32'h0000_0000, 1'b0};
        tbl[1] = '{1, 0, 32'h0000_0004, 1'b0};
        tbl[2] = '{0, 0, 32'h0000_0008, 1'b0};
        tbl[3] = '{2, 5, 32'h0000_000C, 1'b0};
        tbl[4] = '{0, 1, 32'h0000_0040, 1'b0};
        tbl[5] = '{1, 2, 32'h0000_0200, 1'b1};

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
        redirect_en = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0000);
        check("rst_wrap_addr", wr_imem_addr, 32'hFFFF_FFFC);
        check("rst_instr", instr, 32'h0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_pc_plus4", pc_plus4, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_fetch(tbl[i]);
            if (i == 0) check("wrap_addr", wr_imem_addr, 32'h0000_0000);
        end

        // Redirect in the same cycle as an ack: ack is dropped
        check("pre_redir_addr", imem_addr, 32'h0000_0010);
        imem_rdata = mem_word(32'h0000_0010); imem_ack = 1'b1;
        redirect_en = 1'b1; redirect_pc = 32'h0000_0043;
        @(negedge clk);
        imem_ack = 1'b0; redirect_en = 1'b0;
        check("redir_valid", 32'(instr_valid), 32'd0);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0040);
        repeat (2) @(negedge clk);
        check("redir_valid_hold", 32'(instr_valid), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        check("count_after_discard", fetch_count, 32'd4);
`endif
        do_fetch(tbl[4]);

        redirect_en = 1'b1; redirect_pc = 32'h0000_0201;
        @(negedge clk);
        redirect_en = 1'b0;
        check("redir_fetch_addr", imem_addr, 32'h0000_0200);
        do_fetch(tbl[5]);

        // Halted: stimulus must have no effect
        ok = 1'b1;
        redirect_en = 1'b1; redirect_pc = 32'h0000_0080; imem_ack = 1'b1; id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (instr_valid !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b1 ||
                imem_addr !== 32'h0000_0200) ok = 1'b0;
        end
        redirect_en = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
        check("halted_sticky", 32'(ok), 32'd1);
`ifdef IFETCH_PERF_CNT_EN
        check("count_after_halt", fetch_count, 32'd6);
`endif

        // Reset out of HALTED, then reset over an outstanding request
        rst = 1'b1;
        @(negedge clk);
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_addr", imem_addr, 32'h0000_0000);
`ifdef IFETCH_PERF_CNT_EN
        check("rst2_count", fetch_count, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("rst2_req_up", 32'(imem_req), 32'd1);
        imem_rdata = mem_word(32'h0); imem_ack = 1'b1; rst = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; rst = 1'b0;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_addr", imem_addr, 32'h0000_0000);
        check("midrst_wrap_addr", wr_imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check("midrst_ack_ignored", 32'(instr_valid), 32'd0);
        do_fetch(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of control_logic.
- Holds the PC, requests instruction words from instruction memory over a req/ack handshake, and registers the returned word into an IF/ID output register.
- Presents instr[31:26] as opcode to control_logic, and handles branch/jump redirects and the halt opcode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OPCODE, 6'b11_1111, opcode that stops fetching.
- PC_STEP, 4, PC increment in bytes per sequential fetch.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals the current PC.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- imem_ack  input  1  memory completes the request this cycle.
- instr  output  32  registered instruction.
- opcode  output  6  instr[31:26]; connects to control_logic opcode.
- pc_plus4  output  32  PC of instr plus PC_STEP, for branch/jump target math.
- instr_valid  output  1  instr/opcode/pc_plus4 are valid.
- id_ready  input  1  decode accepts the instruction this cycle.
- redirect_en  input  1  taken branch or jump (from branch_en/jump_en resolution).
- redirect_pc  input  32  new PC when redirect_en=1.
- halted  output  1  halt opcode consumed; fetching stopped.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC, instr=0, opcode=0, pc_plus4=0, instr_valid=0, halted=0.
  - imem_req first rises in the cycle after rst deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ack: instr<=imem_rdata, pc_plus4<=pc+PC_STEP, instr_valid<=1, go ISSUE.
    - Latency: ack in cycle N gives instr_valid=1 in cycle N+1.
    - imem_req stays high and imem_addr stays stable until ack.
  - ISSUE: imem_req=0. instr, opcode and pc_plus4 hold stable while instr_valid=1 and id_ready=0.
    - On id_ready=1 with opcode!=HALT_OPCODE: pc<=pc+PC_STEP, instr_valid<=0, go FETCH.
    - On id_ready=1 with opcode==HALT_OPCODE: instr_valid<=0, halted<=1, go HALTED. The halt word is delivered to decode exactly once.
  - HALTED: imem_req=0, instr_valid=0, halted=1. Only rst leaves this state.
- Redirect: in FETCH or ISSUE, redirect_en=1 has priority over ack and id_ready.
  - pc<=redirect_pc with bits [1:0] forced to 0; instr_valid<=0; go FETCH.
  - An imem_ack in the same cycle is discarded.
  - Redirect is ignored in HALTED.
- Arithmetic: PC adds are modulo 2^32. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000; no flag is raised.
- opcode is a wire of instr[31:26], so it is always consistent with instr.
- Reset mid-operation: any outstanding request is abandoned and imem_req drops in the same edge. An ack arriving while rst=1 is ignored. The memory model must tolerate a dropped request.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined: adds output fetch_count[31:0].
  - Resets to 0.
  - Increments by 1 on every accepted ack that is not discarded by a redirect.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: no port, no counter logic. All other behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants (OP_RTYPE=6'b00_0000, OP_ADDI=6'b00_1000, OP_LW=6'b10_0011, OP_SW=6'b10_1011, OP_BEQ=6'b00_0100, OP_J=6'b00_0010, OP_HALT=6'b11_1111).
  - The fetch state enumeration (FETCH, ISSUE, HALTED).
  - PC_STEP.
- One sub-module is natural: pc_reg. It holds the PC and implements increment, redirect with low-bit masking, and reset load. instr_fetch owns the FSM and the IF/ID register.

Test Plan:
- Sequential fetch: rst 2 cycles; memory acks 1 cycle after req with words at 0x0, 0x4, 0x8; id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid one cycle after each ack; pc_plus4=0x4, 0x8, 0xC.
- Decode stall: hold id_ready=0 for 5 cycles with instr=32'h2008_0005 -> instr, opcode=6'b00_1000 and instr_valid stable for all 5 cycles; imem_req=0; fetch resumes at pc+4 after release.
- Redirect vs ack: in FETCH at pc=0x10, assert redirect_en with redirect_pc=0x43 in the same cycle as imem_ack -> ack discarded; next imem_addr=0x40; instr_valid stays 0.
- Halt: deliver 32'hFC00_0000 and accept it -> instr_valid pulses once with opcode=6'b11_1111; then halted=1 and imem_req=0 forever; a later redirect_en has no effect.
- Wrap and reset: RESET_PC=32'hFFFF_FFFC; after one fetch, next imem_addr=0x0. Assert rst while imem_req=1 -> next cycle imem_req=0, instr_valid=0, imem_addr=RESET_PC.
- With IFETCH_PERF_CNT_EN: 3 fetches plus 1 discarded ack -> fetch_count=3.
